// File: rtl/uart_word_tx.sv
// UART transmitter that sends one 32-bit word per frame: a start bit, then 32 data bits
// (most-significant byte first, LSB first within each byte), then STOP_BITS stop bits.
module uart_word_tx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx,
  output logic        busy,
  output logic        tx_done
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [4:0]     STOP_LAST = 5'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [4:0]    bit_cnt;
  logic [31:0]   shreg;
  logic          baud_wrap;

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // Serial position n maps to byte (3 - n[4:3]), bit n[2:0]: MSB byte first, LSB first inside it.
  function automatic logic word_bit(input logic [31:0] w, input logic [4:0] n);
    return w[{~n[4:3], n[2:0]}];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
            state    <= START;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx       <= word_bit(shreg, 5'd0);
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_cnt == 5'd31) begin
              state   <= STOP;
              bit_cnt <= '0;
              tx      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              tx      <= word_bit(shreg, bit_cnt + 5'd1);
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          // bit_cnt is reused here to count stop-bit times.
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              state    <= IDLE;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
            // Registered pulse lands on the final cycle of the stop period.
            if (bit_cnt == STOP_LAST && baud_cnt == BAUD_PRE) tx_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: three instances (868 clk/bit, 4 clk/bit, 5 clk/bit with
// two stop bits) checked against a bit-time waveform model and a sampling serial receiver model.
module tb_uart_word_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n_v;
  logic [2:0]  valid_v;
  logic [31:0] data_v [3];
  logic [2:0]  ready_v, tx_v, busy_v, done_v;

  int checks   = 0;
  int failures = 0;

  logic        trace_q[$];
  logic [31:0] dec_words[$];
  int          dec_starts[$];
  int          dec_ferr;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_word_tx #(
      .CLKS_PER_BIT(g == 0 ? 868 : (g == 1 ? 4 : 5)),
      .STOP_BITS   (g == 2 ? 2 : 1)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n_v[g]),
      .tx_data (data_v[g]),
      .tx_valid(valid_v[g]),
      .tx_ready(ready_v[g]),
      .tx      (tx_v[g]),
      .busy    (busy_v[g]),
      .tx_done (done_v[g])
    );
  end

  function automatic int cpb_of(input int d);
    return (d == 0) ? 868 : ((d == 1) ? 4 : 5);
  endfunction

  function automatic int sb_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  // Expected line level during bit time b of a frame carrying w.
  function automatic logic exp_bit(input logic [31:0] w, input int b);
    int n;
    if (b == 0) return 1'b0;
    if (b >= 1 && b <= 32) begin
      n = b - 1;
      return w[8 * (3 - n / 8) + n % 8];
    end
    return 1'b1;
  endfunction

  // Receiver model: find start bits, sample mid-bit, assemble bytes MSB byte first.
  function automatic void decode(input int cpb);
    int i, c;
    logic [31:0] w;
    logic [7:0]  by;
    dec_words.delete();
    dec_starts.delete();
    dec_ferr = 0;
    i = 0;
    while (i < trace_q.size()) begin
      if (trace_q[i] === 1'b0 && (i + 33 * cpb + cpb / 2) < trace_q.size()
          && trace_q[i + cpb / 2] === 1'b0) begin
        w = '0;
        for (int by_i = 0; by_i < 4; by_i++) begin
          by = '0;
          for (int b = 0; b < 8; b++) by[b] = trace_q[i + (1 + 8 * by_i + b) * cpb + cpb / 2];
          w = {w[23:0], by};
        end
        c = i + 33 * cpb + cpb / 2;
        if (trace_q[c] === 1'b1) begin
          dec_words.push_back(w);
          dec_starts.push_back(i);
        end else begin
          dec_ferr++;
        end
        i = c + 1;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word on instance d and checks the whole frame cycle by cycle.
  task automatic frame_check(input int d, input logic [31:0] word, input bit scramble,
                             input string name, output int busy_cyc, output int low_cyc);
    int cpb, sb, len, werr, first_k, hsk_err, done_cnt, done_k, w;
    logic [31:0] got;
    cpb = cpb_of(d);
    sb  = sb_of(d);
    len = (33 + sb) * cpb;
    werr = 0; first_k = -1; hsk_err = 0; done_cnt = 0; done_k = -1;
    busy_cyc = 0; low_cyc = 0; w = 0;
    while (ready_v[d] !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (ready_v[d] !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_ready: tx_ready=%b, required 1", name, ready_v[d]);
      return;
    end
    data_v[d]  = word;
    valid_v[d] = 1'b1;
    tick();
    valid_v[d] = 1'b0;
    trace_q.delete();
    for (int k = 0; k <= len; k++) begin
      if (k > 0) begin
        if (scramble) data_v[d] = $urandom;
        tick();
      end
      trace_q.push_back(tx_v[d]);
      if (tx_v[d] !== ((k < len) ? exp_bit(word, k / cpb) : 1'b1)) begin
        if (werr == 0) first_k = k;
        werr++;
      end
      if (busy_v[d] === 1'b1) busy_cyc++;
      if (tx_v[d] === 1'b0) low_cyc++;
      if (k < len && (ready_v[d] !== 1'b0 || busy_v[d] !== 1'b1)) hsk_err++;
      if (done_v[d] === 1'b1) begin
        done_cnt++;
        done_k = k;
      end
    end
    checks++;
    if (werr != 0) begin
      failures++;
      $display("FAIL %s waveform: %0d wrong tx cycles (first at %0d), required 0", name, werr, first_k);
    end
    checks++;
    if (hsk_err != 0) begin
      failures++;
      $display("FAIL %s ready_busy: %0d cycles wrong in frame, required 0", name, hsk_err);
    end
    checks++;
    if (ready_v[d] !== 1'b1 || busy_v[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s frame_end: tx_ready=%b busy=%b at cycle %0d, required 1/0",
               name, ready_v[d], busy_v[d], len);
    end
    checks++;
    if (done_cnt != 1 || done_k != len - 1) begin
      failures++;
      $display("FAIL %s tx_done: %0d pulses last at cycle %0d, required 1 at cycle %0d",
               name, done_cnt, done_k, len - 1);
    end
    decode(cpb);
    got = (dec_words.size() > 0) ? dec_words[0] : 32'hxxxxxxxx;
    checks++;
    if (dec_words.size() != 1 || got !== word) begin
      failures++;
      $display("FAIL %s decode: %0d frames word %h, required 1 frame word %h",
               name, dec_words.size(), got, word);
    end
  endtask

  task automatic test_reset();
    valid_v = '0;
    for (int d = 0; d < 3; d++) data_v[d] = '0;
    rst_n_v = 3'b111;
    #1;
    rst_n_v = 3'b000;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (tx_v[d] !== 1'b1) begin
        failures++; $display("FAIL reset_tx[%0d]: got %b, required 1", d, tx_v[d]);
      end
      checks++;
      if (ready_v[d] !== 1'b1) begin
        failures++; $display("FAIL reset_ready[%0d]: got %b, required 1", d, ready_v[d]);
      end
      checks++;
      if (busy_v[d] !== 1'b0) begin
        failures++; $display("FAIL reset_busy[%0d]: got %b, required 0", d, busy_v[d]);
      end
      checks++;
      if (done_v[d] !== 1'b0) begin
        failures++; $display("FAIL reset_done[%0d]: got %b, required 0", d, done_v[d]);
      end
    end
    repeat (3) tick();
    rst_n_v = 3'b111;
    tick();
  endtask

  task automatic test_basic_frame();
    int bc, lc;
    logic [7:0] first_byte;
    frame_check(0, 32'h41424344, 1'b0, "basic", bc, lc);
    for (int b = 0; b < 8; b++) first_byte[b] = trace_q[(b + 1) * 868 + 434];
    checks++;
    if (first_byte !== 8'h41) begin
      failures++; $display("FAIL basic_first_byte: got %h, required 41", first_byte);
    end
    checks++;
    if (bc != 34 * 868) begin
      failures++; $display("FAIL basic_busy_len: got %0d, required %0d", bc, 34 * 868);
    end
  endtask

  task automatic test_timing();
    int bc, lc;
    frame_check(1, 32'hFFFFFFFF, 1'b0, "timing", bc, lc);
    checks++;
    if (lc != 4) begin
      failures++; $display("FAIL timing_start_low: got %0d cycles, required 4", lc);
    end
    checks++;
    if (bc != 136) begin
      failures++; $display("FAIL timing_busy_len: got %0d cycles, required 136", bc);
    end
  endtask

  task automatic test_back_to_back();
    int len, total, dones, w;
    logic [31:0] w0, w1;
    len = 136; total = 3 * (len + 1) + 20; dones = 0; w = 0;
    while (ready_v[1] !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    data_v[1]  = 32'h00000000;
    valid_v[1] = 1'b1;
    tick();
    data_v[1]  = 32'hA5A5A5A5;
    trace_q.delete();
    for (int k = 0; k <= total; k++) begin
      if (k > 0) tick();
      trace_q.push_back(tx_v[1]);
      if (done_v[1] === 1'b1) dones++;
      if (k == len + 1) valid_v[1] = 1'b0;
      if (k == len + 41) begin
        valid_v[1] = 1'b1;
        data_v[1]  = 32'h12345678;
      end
      if (k == len + 42) valid_v[1] = 1'b0;
    end
    decode(4);
    checks++;
    if (dec_words.size() != 2 || dec_ferr != 0) begin
      failures++;
      $display("FAIL b2b_frames: got %0d frames (%0d framing errors), required 2",
               dec_words.size(), dec_ferr);
    end else begin
      w0 = dec_words[0];
      w1 = dec_words[1];
      checks++;
      if (w0 !== 32'h00000000 || w1 !== 32'hA5A5A5A5) begin
        failures++; $display("FAIL b2b_words: got %h %h, required 00000000 a5a5a5a5", w0, w1);
      end
      checks++;
      if (dec_starts[1] - dec_starts[0] != len + 1) begin
        failures++;
        $display("FAIL b2b_gap: start spacing %0d, required %0d", dec_starts[1] - dec_starts[0], len + 1);
      end
    end
    checks++;
    if (dones != 2) begin
      failures++; $display("FAIL b2b_done_count: got %0d, required 2", dones);
    end
  endtask

  task automatic test_data_stability();
    int bc, lc;
    frame_check(1, 32'hDEADBEEF, 1'b1, "stability", bc, lc);
  endtask

  task automatic test_reset_mid_frame();
    int bc, lc, errs, w;
    w = 0;
    while (ready_v[1] !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    data_v[1]  = $urandom;
    valid_v[1] = 1'b1;
    tick();
    valid_v[1] = 1'b0;
    for (int k = 1; k <= 11 * 4 + 1; k++) tick();
    checks++;
    if (busy_v[1] !== 1'b1) begin
      failures++; $display("FAIL midrst_pre_busy: got %b, required 1", busy_v[1]);
    end
    #2;
    rst_n_v[1] = 1'b0;
    #1;
    checks++;
    if (tx_v[1] !== 1'b1) begin
      failures++; $display("FAIL midrst_tx: got %b, required 1", tx_v[1]);
    end
    checks++;
    if (busy_v[1] !== 1'b0 || ready_v[1] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_hs: busy=%b tx_ready=%b, required 0/1", busy_v[1], ready_v[1]);
    end
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done_v[1] !== 1'b0 || tx_v[1] !== 1'b1) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++; $display("FAIL midrst_hold: %0d bad cycles during reset, required 0", errs);
    end
    #2;
    rst_n_v[1] = 1'b1;
    frame_check(1, 32'h0000005A, 1'b0, "after_reset", bc, lc);
  endtask

  task automatic test_stop_bits2();
    int bc, lc, run, k;
    frame_check(2, 32'h80000001, 1'b0, "stop2", bc, lc);
    run = 0;
    k = 35 * 5 - 1;
    while (k >= 0 && trace_q[k] === 1'b1) begin
      run++;
      k--;
    end
    checks++;
    if (run != 10) begin
      failures++; $display("FAIL stop2_stop_len: got %0d high cycles, required 10", run);
    end
    checks++;
    if (bc != 175) begin
      failures++; $display("FAIL stop2_frame_len: got %0d cycles, required 175", bc);
    end
  endtask

  task automatic test_random_words();
    int bc, lc;
    for (int i = 0; i < 4; i++) begin
      frame_check(1, $urandom, 1'b0, "random_cpb4", bc, lc);
      frame_check(2, $urandom, 1'b1, "random_stop2", bc, lc);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timing();
    test_back_to_back();
    test_data_stability();
    test_reset_mid_frame();
    test_stop_bits2();
    test_random_words();
    test_basic_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
